systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_ctrl_if.sv | 26 ++
 rtl/systolic_ctrl.sv | 104 ++++++++++
 tb/tb_systolic_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/systolic_ctrl_if.sv
// Control bundle between the systolic array sequencer and its operand feeders / MAC cells.
interface systolic_ctrl_if #(
  parameter int DIM = 8,
  parameter int CW  = $clog2(3*DIM)
);
  logic                    start;
  logic                    load_c;
  logic                    hold;
  logic                    mac_en;
  logic                    mac_wren;
  logic [$clog2(DIM)-1:0]  c_row_sel;
  logic [DIM-1:0]          feed_valid;
  logic [CW-1:0]           feed_idx;
  logic                    busy;
  logic                    done;

  modport slave (
    input  start, load_c, hold,
    output mac_en, mac_wren, c_row_sel, feed_valid, feed_idx, busy, done
  );

  modport master (
    output start, load_c, hold,
    input  mac_en, mac_wren, c_row_sel, feed_valid, feed_idx, busy, done
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for a DIM x DIM systolic MAC array: optional accumulator preload,
// skewed operand feed over 3*DIM-2 steps, then a one-cycle done pulse.
module systolic_ctrl #(
  parameter int DIM = 8,
  parameter int CW  = $clog2(3*DIM)
) (
  input  logic           clk,
  input  logic           rst,
  systolic_ctrl_if.slave bus
);
  localparam int RW = $clog2(DIM);
  localparam logic [CW-1:0] LOAD_LAST = CW'(DIM - 1);
  localparam logic [CW-1:0] COMP_LAST = CW'(3*DIM - 3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_C,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [DIM-1:0]  w_lane_hit;
  logic            w_feed_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_feed_on     = 1'b0;
    bus.mac_en    = 1'b0;
    bus.mac_wren  = 1'b0;
    bus.c_row_sel = '0;
    bus.feed_idx  = '0;
    bus.busy      = (r_state != S_IDLE);
    bus.done      = (r_state == S_DONE);
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = bus.load_c ? S_LOAD_C : S_COMPUTE;
          w_cnt_next   = '0;
        end
      end
      S_LOAD_C: begin
        bus.c_row_sel = r_cnt[RW-1:0];
        bus.mac_en    = !bus.hold;
        bus.mac_wren  = !bus.hold;
        if (!bus.hold) begin
          if (r_cnt == LOAD_LAST) begin
            w_state_next = S_COMPUTE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        bus.feed_idx = r_cnt;
        bus.mac_en   = !bus.hold;
        w_feed_on    = !bus.hold;
        if (!bus.hold) begin
          if (r_cnt == COMP_LAST) begin
            w_state_next = S_DONE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Lane gi is live for steps gi..gi+DIM-1; t-gi wraps to a large value when t < gi.
  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_lane
      logic [CW:0] w_diff;
      assign w_diff         = {1'b0, r_cnt} - (CW+1)'(gi);
      assign w_lane_hit[gi] = (w_diff < (CW+1)'(DIM));
    end
  endgenerate

  assign bus.feed_valid = w_lane_hit & {DIM{w_feed_on}};
endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl at DIM=4: fixed vector table, directed corner sequences, random traffic vs. a slot-queue model.
module tb_systolic_ctrl;
  localparam int DIM = 4;
  localparam int CW  = $clog2(3*DIM);

  localparam int K_LOAD = 1;
  localparam int K_COMP = 2;
  localparam int K_DONE = 3;

  typedef struct packed {
    logic       en;
    logic       wren;
    logic [1:0] row;
    logic [3:0] fv;
    logic [3:0] idx;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct packed {
    logic s;
    logic lc;
    logic h;
    exp_t e;
  } vec_t;

  typedef struct {
    int kind;
    int val;
  } slot_t;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;
  slot_t q[$];
  vec_t  tab [17];
  logic [3:0] fv_ref [10];

  always #5 clk = ~clk;

  systolic_ctrl_if #(.DIM(DIM), .CW(CW)) ifc ();
  systolic_ctrl #(.DIM(DIM), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  function automatic exp_t mk(logic en, logic wren, int row, logic [3:0] fv, int idx, logic busy, logic done);
    exp_t e;
    e.en = en; e.wren = wren; e.row = 2'(row); e.fv = fv; e.idx = 4'(idx);
    e.busy = busy; e.done = done;
    return e;
  endfunction

  function automatic exp_t dut_obs();
    return mk(ifc.mac_en, ifc.mac_wren, int'(ifc.c_row_sel), ifc.feed_valid,
              int'(ifc.feed_idx), ifc.busy, ifc.done);
  endfunction

  task automatic check(input exp_t e, input string tag);
    exp_t g;
    g = dut_obs();
    nvec++;
    if (g !== e) begin
      nerr++;
      $display("FAIL %s: got en=%b wr=%b row=%0d fv=%b idx=%0d busy=%b done=%b, want en=%b wr=%b row=%0d fv=%b idx=%0d busy=%b done=%b",
               tag, g.en, g.wren, g.row, g.fv, g.idx, g.busy, g.done,
               e.en, e.wren, e.row, e.fv, e.idx, e.busy, e.done);
    end
  endtask

  // Reference: an operation is a list of work slots; a held load/compute slot is not consumed.
  function automatic exp_t model_exp(logic h);
    exp_t  e;
    slot_t s;
    e = '0;
    if (q.size() != 0) begin
      s = q[0];
      e.busy = 1'b1;
      if (s.kind == K_LOAD) begin
        e.en = !h; e.wren = !h; e.row = 2'(s.val);
      end else if (s.kind == K_COMP) begin
        e.en  = !h;
        e.idx = 4'(s.val);
        for (int i = 0; i < DIM; i++)
          e.fv[i] = !h && (s.val >= i) && (s.val <= i + DIM - 1);
      end else begin
        e.done = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_advance(input logic s, input logic lc, input logic h);
    slot_t n;
    if (q.size() == 0) begin
      if (s) begin
        if (lc)
          for (int r = 0; r < DIM; r++) begin n.kind = K_LOAD; n.val = r; q.push_back(n); end
        for (int t = 0; t < 3*DIM-2; t++) begin n.kind = K_COMP; n.val = t; q.push_back(n); end
        n.kind = K_DONE; n.val = 0; q.push_back(n);
      end
    end else if (!(h && (q[0].kind == K_LOAD || q[0].kind == K_COMP))) begin
      void'(q.pop_front());
    end
  endtask

  task automatic drive(input logic s, input logic lc, input logic h);
    @(posedge clk);
    #1;
    ifc.start  = s;
    ifc.load_c = lc;
    ifc.hold   = h;
    @(negedge clk);
  endtask

  task automatic cyc(input logic s, input logic lc, input logic h, input string tag);
    drive(s, lc, h);
    check(model_exp(h), tag);
    model_advance(s, lc, h);
  endtask

  task automatic run_op(input logic lc, input int hold_t, input int hold_n, input int want_lat, input string tag);
    int   lat;
    int   held;
    logic h;
    lat  = -1;
    held = 0;
    cyc(1'b1, lc, 1'b0, {tag, "_start"});
    for (int n = 1; n <= 40; n++) begin
      h = 1'b0;
      if (held < hold_n && q.size() != 0 && q[0].kind == K_COMP && q[0].val == hold_t) begin
        h = 1'b1;
        held++;
      end
      cyc(1'b0, lc, h, tag);
      if (ifc.done === 1'b1) begin
        lat = n;
        break;
      end
    end
    nvec++;
    if (lat != want_lat) begin
      nerr++;
      $display("FAIL %s_latency: got %0d cycles, want %0d", tag, lat, want_lat);
    end
  endtask

  initial begin
    fv_ref = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
               4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 17; i++) tab[i] = '0;
    tab[0].s  = 1'b1;
    tab[0].lc = 1'b1;
    for (int r = 0; r < 4; r++)  tab[1+r].e = mk(1, 1, r, 4'b0000, 0, 1, 0);
    for (int t = 0; t < 10; t++) tab[5+t].e = mk(1, 0, 0, fv_ref[t], t, 1, 0);
    tab[15].e = mk(0, 0, 0, 4'b0000, 0, 1, 1);

    rst = 1'b1;
    ifc.start = 1'b0; ifc.load_c = 1'b0; ifc.hold = 1'b0;
    repeat (2) @(negedge clk);
    check('0, "reset_state");
    @(posedge clk); #1 rst = 1'b0;

    // Full preload + compute sequence against the fixed table.
    for (int i = 0; i < 17; i++) begin
      drive(tab[i].s, tab[i].lc, tab[i].h);
      check(tab[i].e, $sformatf("table_cycle%0d", i));
    end

    run_op(1'b0, -1, 0, 11, "noload");
    run_op(1'b1, -1, 0, 15, "load");
    run_op(1'b0, 5, 3, 14, "hold_t5");
    run_op(1'b1, 2, 2, 17, "hold_load");

    // Reset in the middle of COMPUTE at step 4.
    cyc(1'b1, 1'b0, 1'b0, "abort_start");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, "abort_pre");
    #2 rst = 1'b1;
    #1 check('0, "abort_async_reset");
    q.delete();
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, "post_reset_idle");
    run_op(1'b1, -1, 0, 15, "after_reset");

    for (int i = 0; i < 36; i++) cyc(1'b1, 1'b0, 1'b0, "start_held");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, "drain");

    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 4) == 0), "random");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
